inst_fetch_ctrl: RTL
====================

// Module: inst_fetch_ctrl
// PURPOSE
// Sequences instruction fetch between the PC/IF register stage and a variable-latency
// SRAM-like instruction bus (req/addr_ok/data_ok). One outstanding request at a time.
// Holds fetched words while the pipeline stalls, discards responses cancelled by a flush,
// and raises a stall request to the pipeline controller while a fetch is in flight.
// PARAMETERS
// TIMEOUT   16'd0   cycles in WAIT/CANCEL before the timeout flag is raised; 0 disables it
// CNT_W     16      width of the timeout counter
// PORTS
// clk            in   1   clock, rising edge
// rst_n          in   1   asynchronous active-low reset
// fetch_en_i     in   1   PC stage wants a fetch (inst_sram_en)
// fetch_addr_i   in   32  address to fetch (next-PC)
// flush_i        in   1   pipeline flush (pc flush); cancels current fetch
// stall_i        in   1   IF/ID cannot accept an instruction this cycle
// inst_req       out  1   bus request
// inst_addr      out  32  bus address, registered, stable while inst_req=1
// inst_addr_ok   in   1   bus accepted the address (valid only while inst_req=1)
// inst_data_ok   in   1   bus read data valid
// inst_rdata     in   32  bus read data
// inst_o         out  32  fetched instruction
// inst_valid_o   out  1   inst_o valid
// if_stallreq_o  out  1   stall request to controller
// timeout_o      out  1   sticky: bus response overdue
// BEHAVIOUR
// Reset (async, rst_n=0): state=IDLE; all outputs 0; addr_q, inst_q, counter = 0.
// States: IDLE, REQ, WAIT, HOLD, CANCEL. inst_req=1 only in REQ. inst_valid_o=1 only in HOLD.
// IDLE: fetch_en_i & !flush_i -> addr_q<=fetch_addr_i, REQ; otherwise stay.
// REQ: inst_addr=addr_q.
//   addr_ok & !flush_i -> WAIT.  addr_ok & flush_i -> CANCEL.
//   !addr_ok & flush_i -> IDLE (request withdrawn; never accepted).
// WAIT: data_ok & !flush_i -> inst_q<=inst_rdata, HOLD.  data_ok & flush_i -> IDLE (discard).
//   !data_ok & flush_i -> CANCEL.
// HOLD: inst_o=inst_q, inst_valid_o=1.  flush_i -> IDLE (word dropped).
//   stall_i -> stay, inst_q unchanged.
//   !stall_i: word consumed this cycle; fetch_en_i -> addr_q<=fetch_addr_i, REQ; else IDLE.
// CANCEL: wait for data_ok -> IDLE, rdata discarded; flush_i and fetch_en_i ignored.
// data_ok outside WAIT/CANCEL is ignored; addr_ok outside REQ is ignored.
// if_stallreq_o = (state in REQ,WAIT,CANCEL) | (state==IDLE & fetch_en_i). Never set in HOLD.
// Best-case latency: fetch_en_i in cycle 0 -> REQ cycle 1 (addr_ok) -> WAIT cycle 2
//   (data_ok) -> inst_valid_o in cycle 3.
// Timeout: counter clears on entry to WAIT/CANCEL and increments each cycle there,
//   saturating at all-ones. If TIMEOUT!=0 and counter==TIMEOUT-1, timeout_o<=1 (sticky
//   until reset). State is not changed by timeout.
// Reset mid-operation returns to IDLE immediately. The bus slave shares rst_n, so no
//   response from a pre-reset request arrives.
// TESTING
// 1. Zero-wait: fetch_en=1, addr=0xbfc00000, addr_ok in REQ, data_ok=0x3c08bfaf next cycle
//    -> inst_req only in cycle 1; inst_valid_o=1, inst_o=0x3c08bfaf in cycle 3.
// 2. Stall hold: as 1 with stall_i=1 for 4 cycles in HOLD -> inst_valid_o, inst_o held
//    4 cycles; no inst_req; REQ for next addr the cycle after stall_i drops.
// 3. Flush in WAIT: addr accepted, flush_i before data_ok, data_ok 3 cycles later
//    -> CANCEL; inst_valid_o stays 0; if_stallreq_o=1 until the data_ok cycle; IDLE after.
// 4. Flush in REQ with addr_ok=0 -> IDLE next cycle, inst_req drops. Flush with addr_ok=1
//    -> CANCEL.
// 5. Timeout: TIMEOUT=8, data_ok withheld -> timeout_o rises 8 cycles after entry to WAIT,
//    stays 1 after data_ok; async rst_n pulse clears it and the state.

Source files
------------

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: single-outstanding instruction fetch sequencer for an addr_ok/data_ok SRAM-like bus
module inst_fetch_ctrl #(
  parameter logic [15:0] TIMEOUT = 16'd0,
  parameter int          CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en_i,
  input  logic [31:0] fetch_addr_i,
  input  logic        flush_i,
  input  logic        stall_i,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        if_stallreq_o,
  output logic        timeout_o
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, CANCEL} state_t;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 16'd1);
  state_t           state, ns;
  logic [31:0]      addr_q, inst_q;
  logic [CNT_W-1:0] cnt;
  logic             waiting, entering;
  always_comb begin
    ns = state;
    case (state)
      IDLE:    ns = fetch_en_i && !flush_i ? REQ : IDLE;
      REQ:     ns = inst_addr_ok ? (flush_i ? CANCEL : WAIT) : (flush_i ? IDLE : REQ);
      WAIT:    ns = inst_data_ok ? (flush_i ? IDLE : HOLD) : (flush_i ? CANCEL : WAIT);
      HOLD:    ns = flush_i ? IDLE : stall_i ? HOLD : fetch_en_i ? REQ : IDLE;
      CANCEL:  ns = inst_data_ok ? IDLE : CANCEL;
      default: ns = IDLE;
    endcase
  end
  assign waiting  = state == WAIT || state == CANCEL;
  assign entering = (ns == WAIT || ns == CANCEL) && ns != state;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      inst_q    <= '0;
      cnt       <= '0;
      timeout_o <= 1'b0;
    end else begin
      state <= ns;
      if (ns == REQ && state != REQ) addr_q <= fetch_addr_i;
      if (state == WAIT && ns == HOLD) inst_q <= inst_rdata;
      if (entering) cnt <= '0;
      else if (waiting && cnt != '1) cnt <= cnt + CNT_W'(1);
      if (TIMEOUT != 16'd0 && waiting && cnt == TO_LAST) timeout_o <= 1'b1;
    end
  end
  assign inst_req      = state == REQ;
  assign inst_addr     = addr_q;
  assign inst_valid_o  = state == HOLD;
  assign inst_o        = inst_valid_o ? inst_q : '0;
  assign if_stallreq_o = inst_req || waiting || (state == IDLE && fetch_en_i);
endmodule
